// File: rtl/adder_sync.sv
// Registered unsigned adder with valid/ready handshakes on both sides.
// The result register holds its value under backpressure; the carry-out is the sum MSB.
module adder_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   sum,
    output logic             out_valid,
    input  logic             out_ready
);

    logic           in_xfer;
    logic           out_xfer;
    logic [WIDTH:0] sum_next;

    // A new operand pair may land whenever the output slot is empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign sum_next = {1'b0, a} + {1'b0, b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            sum       <= sum_next;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_sync.sv
// Self-checking bench for adder_sync: directed corners plus randomized traffic
// against a queue-based reference model of accepted operand pairs.
module tb_adder_sync;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   a, b;
    logic           in_valid;
    logic           in_ready;
    logic [W:0]     sum;
    logic           out_valid;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    int n_drop   = 0;
    int expq[$];

    adder_sync #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every accepted pair must come out once, in order, as the plain sum.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_drop += expq.size();
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                int e;
                e = (expq.size() > 0) ? expq.pop_front() : 32'h3FF;
                check("sb_sum", 32'(sum), 32'(e));
                n_out++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(int'(a) + int'(b));
                n_in++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] ca[4];
        logic [W-1:0] cb[4];
        logic [W:0]   cs[4];
        ca = '{8'h00, 8'hFF, 8'h80, 8'hFF};
        cb = '{8'h00, 8'h01, 8'h80, 8'hFF};
        cs = '{9'h000, 9'h100, 9'h100, 9'h1FE};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        // Corner vectors, one per cycle, full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = ca[i]; b = cb[i]; in_valid = 1'b1;
            step();
            check("corner_valid", 32'(out_valid), 1);
            check("corner_sum", 32'(sum), 32'(cs[i]));
        end
        in_valid = 1'b0;
        step();
        check("corner_drained", 32'(out_valid), 0);

        // Backpressure: the next pair waits while the slot is full.
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        step();
        a = 8'h55; b = 8'h66;
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 32'(sum), 32'h046);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp_next_sum", 32'(sum), 32'h0BB);
        step();
        check("bp_drained", 32'(out_valid), 0);

        // Back-to-back streaming, no bubbles.
        for (int i = 0; i < 3; i++) begin
            a = W'(2 * i + 1); b = W'(2 * i + 2); in_valid = 1'b1;
            step();
            check("stream_valid", 32'(out_valid), 1);
            check("stream_sum", 32'(sum), 32'(4 * i + 3));
        end
        in_valid = 1'b0;
        step();

        // Reset while a result is pending.
        out_ready = 1'b0;
        a = 8'hAB; b = 8'h00; in_valid = 1'b1;
        step();
        check("midrst_pending", 32'(sum), 32'h0AB);
        rst_n = 1'b0; a = 8'h01; b = 8'h01; out_ready = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_sum", 32'(sum), 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        check("midrst_no_emit", 32'(out_valid), 0);

        // Randomized traffic with random backpressure; operands held until accepted.
        void'($urandom(32'hC0FFEE));
        for (int v = 0; v < 1000; v++) begin
            bit acc;
            acc = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
            for (int t = 0; t < 100; t++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = in_ready;
                step();
                if (acc) break;
            end
            if (!acc) check("rand_accept", 0, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && expq.size() != 0; t++) step();
        step();
        check("drain_empty", 32'(expq.size()), 0);
        check("in_out_count", 32'(n_out + n_drop), 32'(n_in));
        check("drop_count", 32'(n_drop), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
